// File: rtl/grf_write_arbiter.sv
// grf_write_arbiter: shares the single register-file write port between the
// pipeline writeback stage (pipe) and the multiply/divide unit (mdu).
//
// - pipe normally has priority; mdu fills idle write slots.
// - A starvation counter forces one mdu slot after MAX_WAIT consecutive
//   denials, stalling pipe for that single cycle.
// - A 32-entry scoreboard flags registers with an mdu result still in flight.
// - Winning writes are registered onto grf_* with one cycle of latency.
//
// Optional feature macro: GRF_WRITE_TRACE_EN
//   defined   -> prints every committed register write in simulation
//   undefined -> no trace code is compiled
module grf_write_arbiter #(
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned CNT_W    = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        pipe_we,
    input  logic [4:0]  pipe_addr,
    input  logic [31:0] pipe_data,
    input  logic [31:0] pipe_pc,
    output logic        pipe_stall,

    input  logic        mdu_valid,
    input  logic [4:0]  mdu_addr,
    input  logic [31:0] mdu_data,
    input  logic [31:0] mdu_pc,
    output logic        mdu_ready,

    input  logic        mdu_issue,
    input  logic [4:0]  mdu_issue_addr,

    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic        rs_pending,
    output logic        rt_pending,

    output logic        grf_we,
    output logic [4:0]  grf_addr,
    output logic [31:0] grf_data,
    output logic [31:0] grf_pc
);

    localparam int unsigned NREGS = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 32;

    // Counter value on which a further denial forces the next slot to mdu
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);
    // Ceiling for the counter; it never wraps past this
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_WAIT);

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_FORCE  = 1'b1
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [NREGS-1:0]   sb_q;
    logic [NREGS-1:0]   sb_d;

    logic               grant_pipe;
    logic               grant_mdu;
    logic               mdu_xfer;
    logic               starve;
    logic               enter_force;

    logic               wr_valid;
    logic [AW-1:0]      wr_addr;
    logic [DW-1:0]      wr_data;
    logic [DW-1:0]      wr_pc;

    // Handshakes and grant selection from current state and live requests
    always_comb begin
        grant_pipe = 1'b0;
        grant_mdu  = 1'b0;
        pipe_stall = 1'b0;
        mdu_ready  = 1'b0;
        unique case (state_q)
            ST_FORCE: begin
                pipe_stall = pipe_we;
                mdu_ready  = 1'b1;
                grant_mdu  = mdu_valid;
            end
            default: begin
                mdu_ready  = !pipe_we;
                grant_pipe = pipe_we;
                grant_mdu  = mdu_valid && !pipe_we;
            end
        endcase
    end

    assign mdu_xfer    = mdu_valid && mdu_ready;
    assign starve      = (state_q == ST_NORMAL) && mdu_valid && pipe_we;
    assign enter_force = starve && (cnt_q == CNT_LAST);

    // Starvation counter: counts consecutive mdu denials, saturating
    always_comb begin
        cnt_d = cnt_q;
        if (!mdu_valid || mdu_xfer) begin
            cnt_d = '0;
        end else if (starve && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Scoreboard update; a new issue overrides a same-cycle retire
    always_comb begin
        sb_d = sb_q;
        if (mdu_xfer) begin
            sb_d[mdu_addr] = 1'b0;
        end
        if (mdu_issue && (mdu_issue_addr != AW'(0))) begin
            sb_d[mdu_issue_addr] = 1'b1;
        end
        sb_d[0] = 1'b0;
    end

    // Write-port mux: selects the granted requester's payload
    always_comb begin
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        wr_pc    = '0;
        if (grant_pipe) begin
            wr_valid = 1'b1;
            wr_addr  = pipe_addr;
            wr_data  = pipe_data;
            wr_pc    = pipe_pc;
        end else if (grant_mdu) begin
            wr_valid = 1'b1;
            wr_addr  = mdu_addr;
            wr_data  = mdu_data;
            wr_pc    = mdu_pc;
        end
    end

    // Pending lookups read the registered scoreboard only; $0 is never pending
    assign rs_pending = (rs_addr != AW'(0)) && sb_q[rs_addr];
    assign rt_pending = (rt_addr != AW'(0)) && sb_q[rt_addr];

    // State, counter, scoreboard and registered write port
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_NORMAL;
            cnt_q    <= '0;
            sb_q     <= '0;
            grf_we   <= 1'b0;
            grf_addr <= '0;
            grf_data <= '0;
            grf_pc   <= '0;
        end else begin
            unique case (state_q)
                ST_FORCE: state_q <= ST_NORMAL;
                default:  state_q <= enter_force ? ST_FORCE : ST_NORMAL;
            endcase
            cnt_q <= cnt_d;
            sb_q  <= sb_d;
            // Writes to $0 are still consumed but never reach the file
            grf_we <= wr_valid && (wr_addr != AW'(0));
            if (wr_valid) begin
                grf_addr <= wr_addr;
                grf_data <= wr_data;
                grf_pc   <= wr_pc;
            end
        end
    end

`ifdef GRF_WRITE_TRACE_EN
    // Simulation trace of every committed register write
    always @(posedge clk) begin
        if (grf_we) begin
            $display("%d@%h: $%d <= %h", $time, grf_pc, grf_addr, grf_data);
        end
    end
`endif

endmodule

// File: tb/tb_grf_write_arbiter.sv
// Self-checking bench for grf_write_arbiter: directed steps then random traffic,
// compared against a cycle-level reference model of the arbitration rules.
module tb_grf_write_arbiter;

    localparam int unsigned MAX_WAIT = 4;

    logic        clk;
    logic        reset;
    logic        pipe_we;
    logic [4:0]  pipe_addr;
    logic [31:0] pipe_data;
    logic [31:0] pipe_pc;
    logic        pipe_stall;
    logic        mdu_valid;
    logic [4:0]  mdu_addr;
    logic [31:0] mdu_data;
    logic [31:0] mdu_pc;
    logic        mdu_ready;
    logic        mdu_issue;
    logic [4:0]  mdu_issue_addr;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic        rs_pending;
    logic        rt_pending;
    logic        grf_we;
    logic [4:0]  grf_addr;
    logic [31:0] grf_data;
    logic [31:0] grf_pc;

    grf_write_arbiter #(.MAX_WAIT(MAX_WAIT), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_data(pipe_data),
        .pipe_pc(pipe_pc), .pipe_stall(pipe_stall),
        .mdu_valid(mdu_valid), .mdu_addr(mdu_addr), .mdu_data(mdu_data),
        .mdu_pc(mdu_pc), .mdu_ready(mdu_ready),
        .mdu_issue(mdu_issue), .mdu_issue_addr(mdu_issue_addr),
        .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_pending(rs_pending), .rt_pending(rt_pending),
        .grf_we(grf_we), .grf_addr(grf_addr), .grf_data(grf_data), .grf_pc(grf_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: pending set, length of current mdu denial run,
    // and the write expected on the register-file port.
    logic [31:0] m_pend;
    int          m_run;
    bit          m_known;
    bit          m_we;
    bit          m_fields;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic [31:0] m_pc;

    logic        obs_stall;
    logic        obs_ready;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: check handshakes mid-cycle, advance the model, check grf_* after the edge
    task automatic cycle();
        bit forced, e_stall, e_ready, e_rs, e_rt, pwin, mwin;
        @(negedge clk);
        forced  = (m_run == int'(MAX_WAIT));
        e_stall = forced && pipe_we;
        e_ready = forced || !pipe_we;
        e_rs    = (rs_addr != 5'd0) && m_pend[rs_addr];
        e_rt    = (rt_addr != 5'd0) && m_pend[rt_addr];
        obs_stall = pipe_stall;
        obs_ready = mdu_ready;
        if (m_known) begin
            chk("pipe_stall", 32'(pipe_stall), 32'(e_stall));
            chk("mdu_ready",  32'(mdu_ready),  32'(e_ready));
            chk("rs_pending", 32'(rs_pending), 32'(e_rs));
            chk("rt_pending", 32'(rt_pending), 32'(e_rt));
        end
        if (reset) begin
            m_known = 1'b1;
            m_pend = '0; m_run = 0;
            m_we = 1'b0; m_fields = 1'b1;
            m_addr = '0; m_data = '0; m_pc = '0;
        end else if (m_known) begin
            pwin = pipe_we && !forced;
            mwin = mdu_valid && e_ready;
            if (pwin) begin
                m_we = (pipe_addr != 5'd0); m_fields = m_we;
                m_addr = pipe_addr; m_data = pipe_data; m_pc = pipe_pc;
            end else if (mwin) begin
                m_we = (mdu_addr != 5'd0); m_fields = m_we;
                m_addr = mdu_addr; m_data = mdu_data; m_pc = mdu_pc;
            end else begin
                m_we = 1'b0; m_fields = 1'b0;
            end
            if (!mdu_valid || mwin) m_run = 0;
            else m_run++;
            if (mwin) m_pend[mdu_addr] = 1'b0;
            if (mdu_issue && mdu_issue_addr != 5'd0) m_pend[mdu_issue_addr] = 1'b1;
        end
        @(posedge clk);
        #1;
        if (m_known) begin
            chk("grf_we", 32'(grf_we), 32'(m_we));
            if (m_fields) begin
                chk("grf_addr", 32'(grf_addr), 32'(m_addr));
                chk("grf_data", grf_data, m_data);
                chk("grf_pc",   grf_pc,   m_pc);
            end
        end
    endtask

    task automatic idle_inputs();
        pipe_we = 1'b0; mdu_valid = 1'b0; mdu_issue = 1'b0;
    endtask

    initial begin
        bit exp_r [7];
        bit exp_s [7];
        m_known = 1'b0; m_pend = '0; m_run = 0;
        m_we = 1'b0; m_fields = 1'b0; m_addr = '0; m_data = '0; m_pc = '0;
        reset = 1'b1;
        pipe_we = 1'b0; pipe_addr = '0; pipe_data = '0; pipe_pc = '0;
        mdu_valid = 1'b0; mdu_addr = '0; mdu_data = '0; mdu_pc = '0;
        mdu_issue = 1'b0; mdu_issue_addr = '0; rs_addr = '0; rt_addr = '0;

        // 1: reset for two cycles, then released
        cycle(); cycle();
        reset = 1'b0;
        rs_addr = 5'd1;
        cycle();
        chk("t1_grf_data", grf_data, 32'h0);
        chk("t1_stall", 32'(obs_stall), 32'h0);

        // 2: pipe-only write
        pipe_we = 1'b1; pipe_addr = 5'd8; pipe_data = 32'h1234; pipe_pc = 32'h3000;
        cycle();
        chk("t2_ready", 32'(obs_ready), 32'h0);
        chk("t2_we",    32'(grf_we), 32'h1);
        chk("t2_data",  grf_data, 32'h1234);
        idle_inputs();
        cycle();

        // 3: mdu-only write after issue
        mdu_issue = 1'b1; mdu_issue_addr = 5'd9; rt_addr = 5'd9;
        cycle();
        mdu_issue = 1'b0;
        for (int k = 0; k < 3; k++) cycle();
        chk("t3_rt_pend_before", 32'(rt_pending), 32'h1);
        mdu_valid = 1'b1; mdu_addr = 5'd9; mdu_data = 32'hABCD; mdu_pc = 32'h3010;
        cycle();
        chk("t3_ready", 32'(obs_ready), 32'h1);
        chk("t3_data",  grf_data, 32'hABCD);
        mdu_valid = 1'b0;
        cycle();
        chk("t3_rt_pend_after", 32'(rt_pending), 32'h0);

        // 4: starvation with both requesters held high
        exp_r = '{0, 0, 0, 0, 1, 0, 0};
        exp_s = '{0, 0, 0, 0, 1, 0, 0};
        pipe_we = 1'b1; pipe_addr = 5'd11; pipe_data = 32'h1111; pipe_pc = 32'h4000;
        mdu_valid = 1'b1; mdu_addr = 5'd10; mdu_data = 32'h5555; mdu_pc = 32'h4004;
        for (int k = 0; k < 7; k++) begin
            cycle();
            chk("t4_ready", 32'(obs_ready), 32'(exp_r[k]));
            chk("t4_stall", 32'(obs_stall), 32'(exp_s[k]));
            if (k == 4) chk("t4_force_data", grf_data, 32'h5555);
            if (k == 5) chk("t4_pipe_data", grf_data, 32'h1111);
        end
        idle_inputs();
        cycle();

        // 5: address-0 writes from each requester
        pipe_we = 1'b1; pipe_addr = 5'd0; pipe_data = 32'hDEAD;
        cycle();
        chk("t5_pipe_we0", 32'(grf_we), 32'h0);
        chk("t5_pipe_stall", 32'(obs_stall), 32'h0);
        pipe_we = 1'b0;
        mdu_issue = 1'b1; mdu_issue_addr = 5'd0; rs_addr = 5'd0;
        mdu_valid = 1'b1; mdu_addr = 5'd0; mdu_data = 32'hBEEF;
        cycle();
        chk("t5_mdu_ready", 32'(obs_ready), 32'h1);
        chk("t5_mdu_we0", 32'(grf_we), 32'h0);
        idle_inputs();
        cycle();
        chk("t5_rs0_pend", 32'(rs_pending), 32'h0);

        // 6: reset during FORCE with scoreboard bits set
        mdu_issue = 1'b1; mdu_issue_addr = 5'd5;
        cycle();
        mdu_issue_addr = 5'd6;
        cycle();
        mdu_issue = 1'b0; rs_addr = 5'd5; rt_addr = 5'd6;
        pipe_we = 1'b1; pipe_addr = 5'd12; pipe_data = 32'h77; pipe_pc = 32'h5000;
        mdu_valid = 1'b1; mdu_addr = 5'd3; mdu_data = 32'h99; mdu_pc = 32'h5004;
        for (int k = 0; k < 10 && m_run != int'(MAX_WAIT); k++) cycle();
        chk("t6_pend_set", 32'(rs_pending), 32'h1);
        reset = 1'b1;
        cycle();
        chk("t6_in_force", 32'(obs_stall), 32'h1);
        reset = 1'b0;
        mdu_valid = 1'b0;
        cycle();
        chk("t6_stall_normal", 32'(obs_stall), 32'h0);
        chk("t6_rs_clear", 32'(rs_pending), 32'h0);
        chk("t6_rt_clear", 32'(rt_pending), 32'h0);
        idle_inputs();
        cycle();

        // Random traffic honouring hold-while-not-accepted on both requesters
        for (int k = 0; k < 400; k++) begin
            reset = ($urandom_range(0, 49) == 0);
            if (!(pipe_we && obs_stall)) begin
                pipe_we   = ($urandom_range(0, 2) != 0);
                pipe_addr = 5'($urandom_range(0, 31));
                pipe_data = $urandom;
                pipe_pc   = $urandom;
            end
            if (!(mdu_valid && !obs_ready)) begin
                mdu_valid = ($urandom_range(0, 1) != 0);
                mdu_addr  = 5'($urandom_range(0, 31));
                mdu_data  = $urandom;
                mdu_pc    = $urandom;
            end
            mdu_issue      = ($urandom_range(0, 2) == 0);
            mdu_issue_addr = 5'($urandom_range(0, 31));
            rs_addr        = 5'($urandom_range(0, 31));
            rt_addr        = 5'($urandom_range(0, 31));
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
